// File: rtl/result_collector.sv
// result_collector: gathers result words from 8 cluster lanes into one
// valid/ready stream. Each word is tagged with its 1-based source lane.
// Every lane has a one-entry holding slot. A single output register is fed
// by a round-robin arbiter over the full slots.
// Optional build macro RESULT_COLLECTOR_FIXED_PRIO_EN: the arbiter becomes
// fixed priority, where the lowest-numbered full lane wins, and the pointer
// register is removed.
module result_collector #(
    parameter int unsigned input_width = 91
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [input_width-1:0] data_in_1,
    input  logic [input_width-1:0] data_in_2,
    input  logic [input_width-1:0] data_in_3,
    input  logic [input_width-1:0] data_in_4,
    input  logic [input_width-1:0] data_in_5,
    input  logic [input_width-1:0] data_in_6,
    input  logic [input_width-1:0] data_in_7,
    input  logic [input_width-1:0] data_in_8,
    input  logic                   valid_in_1,
    input  logic                   valid_in_2,
    input  logic                   valid_in_3,
    input  logic                   valid_in_4,
    input  logic                   valid_in_5,
    input  logic                   valid_in_6,
    input  logic                   valid_in_7,
    input  logic                   valid_in_8,
    output logic                   ready_out_1,
    output logic                   ready_out_2,
    output logic                   ready_out_3,
    output logic                   ready_out_4,
    output logic                   ready_out_5,
    output logic                   ready_out_6,
    output logic                   ready_out_7,
    output logic                   ready_out_8,
    output logic [input_width-1:0] data_out,
    output logic [3:0]             index_out,
    output logic                   valid_out,
    input  logic                   ready_in
);

    localparam int unsigned NumLanes = 8;

    logic [input_width-1:0] data_in_arr [NumLanes];
    logic [NumLanes-1:0]    valid_in_vec;

    logic [NumLanes-1:0]    full_q;
    logic [input_width-1:0] slot_q [NumLanes];

    logic [input_width-1:0] data_out_q;
    logic [3:0]             index_out_q;
    logic                   valid_out_q;

    logic                   win_found;
    logic [2:0]             win_lane;
    logic                   load_en;
    logic                   load_hit;

    // Internally lane k lives at array position k-1.
    assign data_in_arr[0] = data_in_1;
    assign data_in_arr[1] = data_in_2;
    assign data_in_arr[2] = data_in_3;
    assign data_in_arr[3] = data_in_4;
    assign data_in_arr[4] = data_in_5;
    assign data_in_arr[5] = data_in_6;
    assign data_in_arr[6] = data_in_7;
    assign data_in_arr[7] = data_in_8;

    assign valid_in_vec = {valid_in_8, valid_in_7, valid_in_6, valid_in_5,
                           valid_in_4, valid_in_3, valid_in_2, valid_in_1};

    // Ready depends only on slot state, so there is no path from ready_in.
    assign ready_out_1 = ~full_q[0];
    assign ready_out_2 = ~full_q[1];
    assign ready_out_3 = ~full_q[2];
    assign ready_out_4 = ~full_q[3];
    assign ready_out_5 = ~full_q[4];
    assign ready_out_6 = ~full_q[5];
    assign ready_out_7 = ~full_q[6];
    assign ready_out_8 = ~full_q[7];

    assign data_out  = data_out_q;
    assign index_out = index_out_q;
    assign valid_out = valid_out_q;

    // The output register is free when it is empty or is being drained this cycle.
    assign load_en  = ~valid_out_q | ready_in;
    assign load_hit = load_en & win_found;

`ifdef RESULT_COLLECTOR_FIXED_PRIO_EN
    // Fixed priority: scan downward so the lowest full lane is the last one written.
    always_comb begin
        win_found = 1'b0;
        win_lane  = 3'd0;
        for (int i = NumLanes - 1; i >= 0; i--) begin
            if (full_q[i]) begin
                win_found = 1'b1;
                win_lane  = 3'(i);
            end
        end
    end
`else
    logic [2:0] ptr_q;

    // Round robin: search starts one past the last winner and wraps from lane 8 to lane 1.
    always_comb begin
        logic [2:0] idx;
        idx       = 3'd0;
        win_found = 1'b0;
        win_lane  = 3'd0;
        for (int i = 1; i <= NumLanes; i++) begin
            idx = ptr_q + 3'(i);
            if (!win_found && full_q[idx]) begin
                win_found = 1'b1;
                win_lane  = idx;
            end
        end
    end

    // The pointer advances only when a word actually moves to the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd7;
        end else if (load_hit) begin
            ptr_q <= win_lane;
        end
    end
`endif

    // Holding slots: capture when empty, and release when the arbiter takes the word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= '0;
            for (int k = 0; k < NumLanes; k++) begin
                slot_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NumLanes; k++) begin
                // Capture and release cannot hit the same lane: a full slot is never ready.
                if (valid_in_vec[k] && !full_q[k]) begin
                    full_q[k] <= 1'b1;
                    slot_q[k] <= data_in_arr[k];
                end else if (load_hit && (win_lane == 3'(k))) begin
                    full_q[k] <= 1'b0;
                end
            end
        end
    end

    // Output register: reloads back-to-back, and holds while the downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q  <= '0;
            index_out_q <= 4'd0;
            valid_out_q <= 1'b0;
        end else if (load_en) begin
            if (win_found) begin
                data_out_q  <= slot_q[win_lane];
                index_out_q <= {1'b0, win_lane} + 4'd1;
                valid_out_q <= 1'b1;
            end else begin
                // data_out keeps its last value; it carries no meaning while valid_out is 0.
                index_out_q <= 4'd0;
                valid_out_q <= 1'b0;
            end
        end
    end

endmodule
